// File: rtl/fifo_burst_reader.sv
// Drain side of a show-ahead FIFO: pops words and emits valid/ready bursts of up to
// BURST_LEN beats, closing a short burst after TIMEOUT consecutive empty cycles.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_fifo_rd_en,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  input  logic                  i_m_ready,
  output logic                  o_burst_done,
  output logic                  o_busy
);

  // state  | meaning
  // IDLE   | no burst open, hold stage empty
  // ACTIVE | burst open, newest word waits in hold stage
  // CLOSE  | burst ending, hold word leaves with last=1 when output frees
  typedef enum logic [1:0] {IDLE, ACTIVE, CLOSE} state_t;

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  logic                  h_valid_q, h_valid_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic                  done_q, done_d;
  logic                  o_free;
  logic                  pop;

  always_comb begin
    state_d   = state_q;
    h_valid_d = h_valid_q;
    h_data_d  = h_data_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    beat_d    = beat_q;
    idle_d    = idle_q;
    done_d    = o_valid_q & i_m_ready & o_last_q;

    o_free = !o_valid_q | i_m_ready;
    pop    = !rst & !i_fifo_empty & (state_q != CLOSE) & (!h_valid_q | o_free);

    if (o_valid_q && i_m_ready) o_valid_d = 1'b0;

    // The held word's last flag is only known once its successor is popped.
    if (pop) begin
      h_valid_d = 1'b1;
      h_data_d  = i_fifo_rdata;
      idle_d    = '0;
      if (h_valid_q) begin
        o_valid_d = 1'b1;
        o_data_d  = h_data_q;
        o_last_d  = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          beat_d  = BW'(1);
          state_d = (BURST_LEN == 1) ? CLOSE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (pop) begin
          beat_d = beat_q + BW'(1);
          if (beat_q + BW'(1) == BW'(BURST_LEN)) state_d = CLOSE;
        end else if (i_fifo_empty) begin
          if (idle_q == IW'(TIMEOUT - 1)) state_d = CLOSE;
          else                            idle_d  = idle_q + IW'(1);
        end
      end
      CLOSE: begin
        if (o_free) begin
          o_valid_d = 1'b1;
          o_data_d  = h_data_q;
          o_last_d  = 1'b1;
          h_valid_d = 1'b0;
          beat_d    = '0;
          idle_d    = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      h_valid_q <= 1'b0;
      h_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      beat_q    <= '0;
      idle_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      beat_q    <= beat_d;
      idle_q    <= idle_d;
      done_q    <= done_d;
    end
  end

  // Outputs read as zero for the whole reset cycle, not just after the edge.
  assign o_fifo_rd_en = pop;
  assign o_m_valid    = o_valid_q & !rst;
  assign o_m_data     = rst ? '0 : o_data_q;
  assign o_m_last     = o_last_q & !rst;
  assign o_burst_done = done_q & !rst;
  assign o_busy       = !rst & ((state_q != IDLE) | o_valid_q);

endmodule
